// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain engine for the asynchronous FIFO.
// Pops words from the FIFO read port into a two-entry head/skid buffer and
// presents them on a registered valid/ready stream, counting delivered beats.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic [1:0]       level,
  output logic [CNTW-1:0]  rd_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_valid;
  logic             r_run;
  logic [DSIZE-1:0] r_head;
  logic [DSIZE-1:0] r_skid;
  logic [CNTW-1:0]  r_count;

  logic w_pop;
  logic w_take;

  // Pop only from registered state and inputs, so m_ready never reaches rinc.
  assign w_pop  = r_run & en & ~rempty & ~flush & (r_state != TWO);
  assign w_take = r_valid & m_ready;

  assign rinc     = w_pop;
  assign m_valid  = r_valid;
  assign m_data   = r_head;
  assign level    = r_state;
  assign rd_count = r_count;

  // Run flag: holds off the first pop until the edge after reset release.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Buffer FSM: head register drives the stream, skid absorbs one stalled pop.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_pop) begin
            r_state <= ONE;
            r_valid <= 1'b1;
            r_head  <= rdata;
          end
        end
        ONE: begin
          if (w_pop && !w_take) begin
            r_state <= TWO;
            r_skid  <= rdata;
          end else if (w_pop && w_take) begin
            r_head  <= rdata;
          end else if (!w_pop && w_take) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        TWO: begin
          if (w_take) begin
            r_state <= ONE;
            r_head  <= r_skid;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Delivered-beat counter; a take during flush still counts.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_count <= '0;
    end else if (w_take) begin
      r_count <= r_count + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Testbench for fifo_rd_stream: FIFO modelled as a queue, the buffer modelled
// as a queue of popped-but-undelivered words, checked every cycle.
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;
  localparam int CNTW  = 4;

  logic             rclk    = 1'b0;
  logic             rrst_n  = 1'b1;
  logic             en      = 1'b0;
  logic             flush   = 1'b0;
  logic             rempty  = 1'b1;
  logic [DSIZE-1:0] rdata   = '0;
  logic             m_ready = 1'b0;
  logic             rinc;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic [1:0]       level;
  logic [CNTW-1:0]  rd_count;

  fifo_rd_stream #(.DSIZE(DSIZE), .CNTW(CNTW)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .en       (en),
    .flush    (flush),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .level    (level),
    .rd_count (rd_count)
  );

  always #5 rclk = ~rclk;

  byte unsigned fifo_q[$];
  byte unsigned exp_q[$];
  int           m_cnt    = 0;
  bit           m_run    = 1'b0;
  bit           pend_pop = 1'b0;
  bit           exp_pop;
  int           n_tests  = 0;
  int           n_fail   = 0;

  function automatic void upd();
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
  endfunction

  function automatic void push(input byte unsigned v);
    fifo_q.push_back(v);
    upd();
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    m_run = 1'b0;
  endtask

  // Scoreboard monitor: compare against the buffer model, then advance it.
  initial begin
    forever begin
      @(negedge rclk);
      chk("level", {30'd0, level}, exp_q.size());
      chk("m_valid", {31'd0, m_valid}, {31'd0, exp_q.size() != 0});
      chk("rd_count", {28'd0, rd_count}, m_cnt);
      if (exp_q.size() != 0) chk("m_data", {24'd0, m_data}, {24'd0, exp_q[0]});
      exp_pop = m_run && en && !rempty && !flush && (exp_q.size() < 2);
      chk("rinc", {31'd0, rinc}, {31'd0, exp_pop});
      if (rrst_n && exp_q.size() != 0 && m_ready) begin
        void'(exp_q.pop_front());
        m_cnt = (m_cnt + 1) % 16;
      end
      if (rrst_n && flush) exp_q.delete();
      if (exp_pop) begin
        exp_q.push_back(rdata);
        pend_pop = 1'b1;
      end
    end
  end

  // FIFO read-pointer model: the head word leaves once the edge has taken it.
  initial begin
    forever begin
      @(posedge rclk);
      m_run = rrst_n;
      #1;
      if (pend_pop) begin
        void'(fifo_q.pop_front());
        pend_pop = 1'b0;
        upd();
      end
    end
  end

  initial begin
    upd();
    en = 1'b1;
    m_ready = 1'b1;
    #1;
    do_reset();
    push(8'h11); push(8'h22); push(8'h33);
    step(2);
    chk("rst_m_valid", {31'd0, m_valid}, 0);
    chk("rst_m_data", {24'd0, m_data}, 0);
    chk("rst_level", {30'd0, level}, 0);
    chk("rst_rinc", {31'd0, rinc}, 0);
    chk("rst_rd_count", {28'd0, rd_count}, 0);
    rrst_n = 1'b1;
    chk("release_rinc", {31'd0, rinc}, 0);
    step(8);
    chk("preload_count", {28'd0, rd_count}, 3);
    chk("preload_level", {30'd0, level}, 0);

    // Stall: only two words may leave the FIFO.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h40 + i[7:0]);
    step(6);
    chk("stall_level", {30'd0, level}, 2);
    chk("stall_fifo_left", fifo_q.size(), 3);
    chk("stall_rinc", {31'd0, rinc}, 0);
    m_ready = 1'b1;
    step(10);
    chk("stall_count", {28'd0, rd_count}, 8);

    // Alternating ready with a continuous supply.
    for (int i = 0; i < 16; i++) push(i[7:0]);
    for (int i = 0; i < 50; i++) begin
      m_ready = i[0];
      step(1);
    end
    m_ready = 1'b1;
    step(3);
    chk("alt_count", {28'd0, rd_count}, 8);
    chk("alt_level", {30'd0, level}, 0);

    // Flush with two buffered words and a take in the flush cycle.
    m_ready = 1'b0;
    push(8'hA0); push(8'hA1); push(8'hB0);
    step(4);
    chk("fl_level", {30'd0, level}, 2);
    chk("fl_head", {24'd0, m_data}, 8'hA0);
    flush = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("fl_rinc", {31'd0, rinc}, 0);
    step(1);
    flush = 1'b0;
    chk("fl_valid", {31'd0, m_valid}, 0);
    chk("fl_count", {28'd0, rd_count}, 9);
    step(5);
    chk("fl_after_count", {28'd0, rd_count}, 10);
    chk("fl_fifo_drained", fifo_q.size(), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) != 0;
      flush   = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) != 0 && fifo_q.size() < 8) push(8'($urandom));
      step(1);
    end
    flush = 1'b0;
    en = 1'b1;
    m_ready = 1'b1;
    step(20);
    chk("rand_level", {30'd0, level}, 0);

    // Counter wrap: 17 beats on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push(8'hC0 + i[7:0]);
    step(2);
    rrst_n = 1'b1;
    step(25);
    chk("wrap_count", {28'd0, rd_count}, 1);

    // Reset while the buffer is full.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hD0 + i[7:0]);
    step(5);
    chk("mid_level_pre", {30'd0, level}, 2);
    do_reset();
    #1;
    chk("mid_m_valid", {31'd0, m_valid}, 0);
    chk("mid_level", {30'd0, level}, 0);
    chk("mid_rinc", {31'd0, rinc}, 0);
    step(2);
    rrst_n = 1'b1;
    chk("rel_rinc_c1", {31'd0, rinc}, 0);
    step(1);
    chk("rel_rinc_c2", {31'd0, rinc}, 1);
    m_ready = 1'b1;
    step(10);
    chk("end_level", {30'd0, level}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
